// File: rtl/fifo_buffer_param_if.sv
// Handshake and status bundle between a FIFO and the logic that feeds and drains it.
// The master side issues requests and data; the slave side is the FIFO itself.
interface fifo_buffer_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                  enable;
    logic                  flush;
    logic                  write;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output enable, flush, write, data_in, read,
        input  data_out, valid_out, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  enable, flush, write, data_in, read,
        output data_out, valid_out, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );
endinterface

// File: rtl/fifo_buffer_param.sv
// Parametrised single-clock FIFO with registered read data, occupancy count,
// threshold flags, synchronous flush and sticky overflow/underflow flags.
module fifo_buffer_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1
) (
    input logic                clock,
    input logic                reset,
    fifo_buffer_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    // Storage is left unreset so it maps onto block RAM; reset only empties
    // the FIFO logically through the pointers and count.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH:0]   count_next;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  valid_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;

    logic empty_flag;
    logic full_flag;
    logic active;
    logic wr_ok;
    logic rd_ok;
    logic overflow_hit;
    logic underflow_hit;

    // Status flags depend only on the count register, never on this cycle's requests.
    assign empty_flag = (count_reg == '0);
    assign full_flag  = (count_reg == DEPTH_CNT);

    // Request qualification; a read frees a slot, so full plus read still accepts the write.
    always_comb begin
        active        = bus.enable & ~bus.flush;
        wr_ok         = active & bus.write & (~full_flag | bus.read);
        rd_ok         = active & bus.read & ~empty_flag;
        overflow_hit  = active & bus.write & full_flag & ~bus.read;
        underflow_hit = active & bus.read & empty_flag;
        count_next    = count_reg;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Memory write port; the read port below samples the old word on a shared address.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= bus.data_in;
        end
    end

    // Pointers, count, registered read data and sticky error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            data_out_reg  <= '0;
            valid_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (bus.flush) begin
            // Flush empties the FIFO but keeps the last read word visible.
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            valid_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (bus.enable) begin
            valid_reg <= rd_ok;
            if (rd_ok) begin
                data_out_reg <= mem[rd_ptr_reg];
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
            end
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            if (overflow_hit) begin
                overflow_reg <= 1'b1;
            end
            if (underflow_hit) begin
                underflow_reg <= 1'b1;
            end
        end else begin
            valid_reg <= 1'b0;
        end
    end

    assign bus.data_out     = data_out_reg;
    assign bus.valid_out    = valid_reg;
    assign bus.count        = count_reg;
    assign bus.empty        = empty_flag;
    assign bus.full         = full_flag;
    assign bus.almost_empty = (count_reg <= AE_CNT);
    assign bus.almost_full  = (count_reg >= AF_CNT);
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;
endmodule

// File: tb/tb_fifo_buffer_param.sv
// Directed and randomized checks of fifo_buffer_param against a queue-based reference.
module tb_fifo_buffer_param;
    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_buffer_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    fifo_buffer_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, plus the visible registered outputs.
    logic [DW-1:0] q [$];
    logic [DW-1:0] m_dout;
    bit            m_valid;
    bit            m_ovf;
    bit            m_udf;

    int errors = 0;
    int checks = 0;

    task automatic model_reset();
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit fl, input bit wr, input bit rd,
                              input logic [DW-1:0] din);
        int n;
        n = q.size();
        if (fl) begin
            q.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else if (en) begin
            if (rd && n == 0) m_udf = 1'b1;
            if (wr && n == DEPTH && !rd) m_ovf = 1'b1;
            m_valid = (rd && n > 0);
            if (rd && n > 0) m_dout = q.pop_front();
            if (wr && (n < DEPTH || rd)) q.push_back(din);
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".data_out"},     bus_if.data_out,     m_dout);
        chk({tag, ".valid_out"},    bus_if.valid_out,    m_valid);
        chk({tag, ".count"},        bus_if.count,        n);
        chk({tag, ".empty"},        bus_if.empty,        n == 0);
        chk({tag, ".full"},         bus_if.full,         n == DEPTH);
        chk({tag, ".almost_empty"}, bus_if.almost_empty, n <= AE);
        chk({tag, ".almost_full"},  bus_if.almost_full,  n >= AF);
        chk({tag, ".overflow"},     bus_if.overflow,     m_ovf);
        chk({tag, ".underflow"},    bus_if.underflow,    m_udf);
    endtask

    task automatic cycle(input bit en, input bit fl, input bit wr, input bit rd,
                         input logic [DW-1:0] din, input string tag);
        bus_if.enable  = en;
        bus_if.flush   = fl;
        bus_if.write   = wr;
        bus_if.read    = rd;
        bus_if.data_in = din;
        @(posedge clk);
        model_step(en, fl, wr, rd, din);
        #1;
        check_all(tag);
        $display("cycle %-12s en=%0b fl=%0b wr=%0b rd=%0b din=%h -> dout=%h v=%0b cnt=%0d",
                 tag, en, fl, wr, rd, din, bus_if.data_out, bus_if.valid_out, bus_if.count);
    endtask

    initial begin
        logic [DW-1:0] w;
        bus_if.enable  = 1'b0;
        bus_if.flush   = 1'b0;
        bus_if.write   = 1'b0;
        bus_if.read    = 1'b0;
        bus_if.data_in = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        rst = 1'b0;

        // Fill with A0..A7
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 1, 0, DW'(32'hA0 + i), "fill");
        chk("fill.full", bus_if.full, 1'b1);

        // Drain in order
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0, 0, 1, '0, "drain");
            chk("drain.word", bus_if.data_out, DW'(32'hA0 + i));
        end
        cycle(1, 0, 0, 0, '0, "idle");

        // Overflow, one read, then flush
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 1, 0, DW'(32'hA0 + i), "fill2");
        cycle(1, 0, 1, 0, 32'hFF, "overflow");
        chk("overflow.flag", bus_if.overflow, 1'b1);
        cycle(1, 0, 0, 1, '0, "ovf_read");
        cycle(1, 1, 0, 0, '0, "flush");
        chk("flush.hold", bus_if.data_out, 32'hA0);

        // Full with simultaneous read+write
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 1, 0, DW'(32'hA0 + i), "fill3");
        cycle(1, 0, 1, 1, 32'hB0, "full_rw");
        chk("full_rw.word", bus_if.data_out, 32'hA0);
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 1, '0, "drain3");
        chk("drain3.last", bus_if.data_out, 32'hB0);

        // Empty with simultaneous read+write
        cycle(1, 0, 1, 1, 32'hC1, "empty_rw");
        chk("empty_rw.udf", bus_if.underflow, 1'b1);
        cycle(1, 0, 0, 1, '0, "read_c1");
        chk("read_c1.word", bus_if.data_out, 32'hC1);
        cycle(1, 1, 0, 0, '0, "flush2");

        // Pointer wrap, then enable low with both requests
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, $urandom, "wrap_w");
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, '0, "wrap_r");
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, $urandom, "wrap_w2");
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, $urandom, "disabled");

        // Asynchronous reset mid-cycle
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        $display("async reset: dout=%h cnt=%0d", bus_if.data_out, bus_if.count);
        bus_if.enable = 1'b0;
        bus_if.write  = 1'b0;
        bus_if.read   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 0, 1, 0, 32'h5A, "post_rst");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, w, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
